// File: rtl/cpu.sv
// Accumulator CPU: 16x8 instruction and data memories, a T0..T4 step counter,
// and an 8-bit AC with a carry flag E that only ADD updates.
module cpu (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] init_ins,
    input  logic [127:0] init_data,
    output logic         halted,
    output logic [7:0]   ac_out,
    output logic [3:0]   pc_out
);

    logic [3:0] PC;
    logic [3:0] AR;
    logic [7:0] IR;
    logic [7:0] AC;
    logic [7:0] DR;
    logic [7:0] TR;
    logic       E;
    logic [2:0] seq_out;
    logic [2:0] seq_d;
    logic       halted_q;
    logic [7:0] alu_out;
    logic [7:0] bus_output;
    logic [7:0] imem [16];
    logic [7:0] dmem [16];

    logic [3:0] op;
    logic [3:0] n;
    logic [8:0] sum9;
    logic       mem_rd;
    logic       exec;

    assign op     = IR[7:4];
    assign n      = IR[3:0];
    assign mem_rd = (op >= 4'h1) && (op <= 4'h4);
    assign exec   = ((seq_out == 3'd3) && !mem_rd) || (seq_out == 3'd4);

    assign halted = halted_q;
    assign ac_out = AC;
    assign pc_out = PC;

    // alu_out defaults to AC so ops that leave AC alone can write it back
    always_comb begin
        sum9    = {1'b0, AC} + {1'b0, DR};
        alu_out = AC;
        case (op)
            4'h0: begin
                if (n == 4'h1) begin
                    alu_out = AC - 8'd1;
                end else if (n == 4'h2) begin
                    alu_out = AC + 8'd1;
                end
            end
            4'h1: alu_out = sum9[7:0];
            4'h2: alu_out = AC - DR;
            4'h3: alu_out = AC & DR;
            4'h4: alu_out = DR;
            4'h6: begin
                case (n)
                    4'h0:    alu_out = 8'h00;
                    4'h1:    alu_out = ~AC;
                    4'h2:    alu_out = {AC[7], AC[7:1]};
                    4'h3:    alu_out = {AC[6:0], 1'b0};
                    4'h4:    alu_out = AC + 8'd1;
                    4'h5:    alu_out = AC - 8'd1;
                    4'h6:    alu_out = (~AC) + 8'd1;
                    default: alu_out = AC;
                endcase
            end
            4'h7:    alu_out = {4'b0, n};
            default: alu_out = AC;
        endcase
    end

    always_comb begin
        bus_output = AC;
        case (seq_out)
            3'd0:    bus_output = {4'b0, PC};
            3'd1:    bus_output = imem[AR];
            3'd2:    bus_output = {4'b0, n};
            3'd3:    bus_output = mem_rd ? dmem[AR] : AC;
            3'd4:    bus_output = DR;
            default: bus_output = AC;
        endcase
    end

    always_comb begin
        seq_d = 3'd0;
        if (halted_q) begin
            seq_d = seq_out;
        end else begin
            case (seq_out)
                3'd0:    seq_d = 3'd1;
                3'd1:    seq_d = 3'd2;
                3'd2:    seq_d = 3'd3;
                3'd3:    seq_d = mem_rd ? 3'd4 : 3'd0;
                default: seq_d = 3'd0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            PC       <= '0;
            AR       <= '0;
            IR       <= '0;
            AC       <= '0;
            DR       <= '0;
            TR       <= '0;
            E        <= 1'b0;
            seq_out  <= '0;
            halted_q <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                imem[i] <= init_ins[8*i +: 8];
                dmem[i] <= init_data[8*i +: 8];
            end
        end else if (!halted_q) begin
            seq_out <= seq_d;
            case (seq_out)
                3'd0: AR <= PC;
                3'd1: begin
                    IR <= imem[AR];
                    PC <= PC + 4'd1;
                end
                3'd2: AR <= n;
                3'd3: begin
                    if (mem_rd) begin
                        DR <= dmem[AR];
                    end
                end
                default: ;
            endcase
            if (exec) begin
                AC <= alu_out;
                if (op == 4'h1) begin
                    E <= sum9[8];
                end
                // later PC assignments win; ops are mutually exclusive
                case (op)
                    4'h0: begin
                        if ((n == 4'h1) && (alu_out == 8'h00)) begin
                            PC <= PC + 4'd1;
                        end
                    end
                    4'h5: begin
                        dmem[AR] <= AC;
                        TR       <= AC;
                    end
                    4'h8: begin
                        TR <= {4'b0, PC};
                        PC <= n;
                    end
                    4'h9: begin
                        if (AC == 8'h00) begin
                            PC <= n;
                        end
                    end
                    4'hF: begin
                        if (n == 4'hF) begin
                            halted_q <= 1'b1;
                        end else if (AC != 8'h00) begin
                            PC <= n;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cpu.sv
// Directed bench for cpu: a table of small programs with final-state
// expectations, plus hand sequences for reset, fetch timing and abort.
module tb_cpu;

    logic         clk;
    logic         rst_n;
    logic [127:0] init_ins;
    logic [127:0] init_data;
    logic         halted;
    logic [7:0]   ac_out;
    logic [3:0]   pc_out;

    int n_chk;
    int n_fail;

    cpu dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .init_ins  (init_ins),
        .init_data (init_data),
        .halted    (halted),
        .ac_out    (ac_out),
        .pc_out    (pc_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string        name;
        logic [127:0] ins;
        logic [127:0] data;
        logic [7:0]   ac;
        logic [3:0]   pc;
        logic         e;
        logic [7:0]   tr;
        logic [3:0]   maddr;
        logic [7:0]   mval;
        int           cyc;
    } prog_t;

    prog_t progs[9];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic load(input logic [127:0] ins, input logic [127:0] data);
        rst_n     = 1'b0;
        init_ins  = ins;
        init_data = data;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic run_halt(output int cyc);
        cyc = 0;
        while (!halted && cyc < 400) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
    endtask

    initial begin
        int   cyc;
        int   guard;
        logic [7:0] pc_hold;
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        init_ins  = '0;
        init_data = '0;

        progs[0] = '{"ld_inc_st", 128'hFF510240, 128'h0A,
                     8'h0B, 4'h4, 1'b0, 8'h0B, 4'h1, 8'h0B, 17};
        progs[1] = '{"skiploop", 128'hFF810173, 128'h0,
                     8'h00, 4'h4, 1'b0, 8'h03, 4'h0, 8'h00, 28};
        progs[2] = '{"regops", 128'hFF626675, 128'h0,
                     8'hFD, 4'h4, 1'b0, 8'h00, 4'h0, 8'h00, 16};
        progs[3] = '{"add_nc", 128'hFF107F, 128'hF0,
                     8'hFF, 4'h3, 1'b0, 8'h00, 4'h0, 8'hF0, 13};
        progs[4] = '{"add_c", 128'hFF107F, 128'hF1,
                     8'h00, 4'h3, 1'b1, 8'h00, 4'h0, 8'hF1, 13};
        progs[5] = '{"wrap", 128'h0000_0000_0000_0000_0000_008F_02FF_0102,
                     128'h0, 8'h01, 4'h3, 1'b0, 8'h05, 4'h0, 8'h00, 32};
        progs[6] = '{"skip15", 128'h0171_0000_0000_0000_0000_0000_0000_FF8E,
                     128'h0, 8'h00, 4'h2, 1'b0, 8'h01, 4'h0, 8'h00, 16};
        progs[7] = '{"alumix", 128'h0000_0000_0000_0000_FF52_6261_6331_2079,
                     128'h0F0A, 8'hF0, 4'h8, 1'b0, 8'hF0, 4'h2, 8'hF0, 34};
        progs[8] = '{"branch", 128'h000000FF_64F26065_FFF89873_FFFF9470,
                     128'h0, 8'h01, 4'hD, 1'b0, 8'h00, 4'h0, 8'h00, 40};

        // reset state and memory load
        init_ins  = 128'hFF510240;
        init_data = 128'h0A;
        repeat (2) @(negedge clk);
        chk("rst_regs", {dut.PC, dut.AR, dut.IR, dut.AC, dut.DR, dut.TR,
                         dut.E, dut.seq_out, halted}, 32'h0);
        chk("rst_dmem0", dut.dmem[0], 8'h0A);
        chk("rst_imem2", dut.imem[2], 8'h51);
        rst_n = 1'b1;
        @(negedge clk);
        chk("fetch_seq", dut.seq_out, 3'd1);
        chk("fetch_ar", dut.AR, 4'h0);
        chk("fetch_bus", dut.bus_output, 8'h40);

        for (int i = 0; i < 9; i++) begin
            load(progs[i].ins, progs[i].data);
            run_halt(cyc);
            chk({progs[i].name, "_cyc"}, cyc, progs[i].cyc);
            chk({progs[i].name, "_ac"}, ac_out, progs[i].ac);
            chk({progs[i].name, "_pc"}, pc_out, progs[i].pc);
            chk({progs[i].name, "_e"}, dut.E, progs[i].e);
            chk({progs[i].name, "_tr"}, dut.TR, progs[i].tr);
            chk({progs[i].name, "_mem"}, dut.dmem[progs[i].maddr],
                progs[i].mval);
            repeat (5) @(negedge clk);
            chk({progs[i].name, "_hold"}, {halted, dut.seq_out, pc_out, ac_out},
                {1'b1, 3'd0, progs[i].pc, progs[i].ac});
        end

        // alu_out must show the NEG result during its execute step
        load(128'hFF626675, 128'h0);
        guard = 0;
        while (!(dut.IR == 8'h66 && dut.seq_out == 3'd3) && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        chk("neg_reach", guard < 40, 1'b1);
        chk("neg_alu", dut.alu_out, 8'hFB);
        chk("neg_bus", dut.bus_output, 8'h05);

        // abort an STA just before its write
        load(128'hFF510240, 128'h0A);
        guard = 0;
        while (!(dut.IR == 8'h51 && dut.seq_out == 3'd3) && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        chk("sta_reach", guard < 40, 1'b1);
        pc_hold = {4'b0, pc_out};
        chk("sta_pre_pc", pc_hold, 8'h03);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_mem", dut.dmem[1], 8'h00);
        chk("abort_regs", {dut.PC, dut.AR, dut.IR, dut.AC, dut.DR, dut.TR,
                           dut.E, dut.seq_out, halted}, 32'h0);
        rst_n = 1'b1;
        run_halt(cyc);
        chk("rerun_cyc", cyc, 17);
        chk("rerun_mem", dut.dmem[1], 8'h0B);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
